// File: rtl/decode_stage_if.sv
// Fetch-to-execute decode bus: fetch handshake inputs plus the decoded entry and retire counter.
interface decode_stage_if #(
  parameter int INSN_WIDTH = 32,
  parameter int XLEN       = 32,
  parameter int PC_WIDTH   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INSN_WIDTH-1:0] in_insn;
  logic [PC_WIDTH-1:0]   in_pc;

  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic [2:0]            fmt;
  logic [XLEN-1:0]       imm;
  logic                  illegal;
  logic [CNT_WIDTH-1:0]  decode_cnt;

  // Fetch/execute side of the bus.
  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, funct3, funct7,
           rs1, rs2, rd, fmt, imm, illegal, decode_cnt
  );

  // Decode stage side of the bus.
  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, funct3, funct7,
           rs1, rs2, rd, fmt, imm, illegal, decode_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: 1-cycle registered decode of fields, format and immediate.
// Output register plus one skid entry; in_ready is registered and drops only when the skid is full.
module decode_stage #(
  parameter int INSN_WIDTH = 32,
  parameter int XLEN       = 32,
  parameter int PC_WIDTH   = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int CNT_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [2:0]            fmt;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  entry_t                dec;
  entry_t                out_q, out_d;
  entry_t                skid_q, skid_d;
  logic                  out_vld_q, out_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [INSN_WIDTH-1:0] insn;
  logic                  accept;
  logic                  drain;

  assign insn   = bus.in_insn;
  assign accept = bus.in_valid && !skid_vld_q;
  assign drain  = out_vld_q && bus.out_ready;

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = insn[6:0];
    dec.funct3  = insn[14:12];
    dec.funct7  = insn[31:25];
    dec.rs1     = ADDR_WIDTH'(insn[19:15]);
    dec.rs2     = ADDR_WIDTH'(insn[24:20]);
    dec.rd      = ADDR_WIDTH'(insn[11:7]);
    unique case (insn[6:0])
      7'b0110011:                                         dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0001111:                                         dec.fmt = FMT_I;
      7'b0100011:                                         dec.fmt = FMT_S;
      7'b1100011:                                         dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:                             dec.fmt = FMT_U;
      7'b1101111:                                         dec.fmt = FMT_J;
      default:                                            dec.fmt = FMT_ILL;
    endcase
    if (insn[1:0] != 2'b11) dec.fmt = FMT_ILL;
    dec.illegal = (dec.fmt == FMT_ILL);

    case (dec.fmt)
      FMT_I:   dec.imm = sext32({{20{insn[31]}}, insn[31:20]});
      FMT_S:   dec.imm = sext32({{20{insn[31]}}, insn[31:25], insn[11:7]});
      FMT_B:   dec.imm = sext32({{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0});
      FMT_U:   dec.imm = sext32({insn[31:12], 12'b0});
      FMT_J:   dec.imm = sext32({{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0});
      default: dec.imm = '0;
    endcase
    // S and B have no destination; illegal entries must not look like a write either.
    if (dec.fmt == FMT_S || dec.fmt == FMT_B || dec.fmt == FMT_ILL) dec.rd = '0;
  end

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q + CNT_WIDTH'(drain);
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      // Skid is older than anything arriving now; in_ready is low whenever it is full.
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = dec;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = !skid_vld_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_pc     = out_q.pc;
  assign bus.opcode     = out_q.opcode;
  assign bus.funct3     = out_q.funct3;
  assign bus.funct7     = out_q.funct7;
  assign bus.rs1        = out_q.rs1;
  assign bus.rs2        = out_q.rs2;
  assign bus.rd         = out_q.rd;
  assign bus.fmt        = out_q.fmt;
  assign bus.imm        = out_q.imm;
  assign bus.illegal    = out_q.illegal;
  assign bus.decode_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected entries queued on input accept, compared on output handshake.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = '0;
  bit          rnd_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.opc = i[6:0];
    e.f3  = i[14:12];
    e.f7  = i[31:25];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    e.ill = 1'b0;
    e.imm = 32'h0;
    case (i[6:0])
      7'h33: e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        e.fmt = 3'd1;
        e.imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        e.rd  = 5'd0;
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.rd  = 5'd0;
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = {i[31:12], 12'h000};
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: begin
        e.fmt = 3'd7;
        e.ill = 1'b1;
        e.rd  = 5'd0;
      end
    endcase
    return e;
  endfunction

  // Monitor: compare on output handshake, then record the input accepted at the same edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        check_eq("cnt", bus.decode_cnt, exp_cnt);
        if (sb.size() == 0) begin
          check_eq("sb_underflow", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check_eq("pc",      bus.out_pc,  mon_e.pc);
          check_eq("opcode",  bus.opcode,  mon_e.opc);
          check_eq("funct3",  bus.funct3,  mon_e.f3);
          check_eq("funct7",  bus.funct7,  mon_e.f7);
          check_eq("rs1",     bus.rs1,     mon_e.rs1);
          check_eq("rs2",     bus.rs2,     mon_e.rs2);
          check_eq("rd",      bus.rd,      mon_e.rd);
          check_eq("fmt",     bus.fmt,     mon_e.fmt);
          check_eq("imm",     bus.imm,     mon_e.imm);
          check_eq("illegal", bus.illegal, mon_e.ill);
        end
        exp_cnt = exp_cnt + 32'd1;
      end
      if (flush) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(cur);
    end
  end

  task automatic send(input logic [31:0] insn, input logic [31:0] pc, input exp_t e);
    int   tries = 0;
    logic acc   = 1'b0;
    cur          = e;
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
    bus.in_pc    = pc;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) check_eq("send_timeout", tries, 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] insn, input logic [31:0] pc);
    send(insn, pc, model(insn, pc));
  endtask

  // Directed vector: format, immediate, rd and illegal come from hand-decoded constants.
  task automatic send_dir(input logic [31:0] insn, input logic [31:0] pc, input logic [2:0] fmt,
                          input logic [31:0] imm, input logic [4:0] rd, input logic ill);
    exp_t e;
    e     = model(insn, pc);
    e.fmt = fmt;
    e.imm = imm;
    e.rd  = rd;
    e.ill = ill;
    send(insn, pc, e);
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (n < 60 && (sb.size() != 0 || bus.out_valid)) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_empty", sb.size(), 0);
    check_eq("drain_vld", bus.out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [6:0] ops[12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                          7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};

  initial begin
    logic [31:0] r;
    bus.in_valid  = 1'b0;
    bus.in_insn   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    #12;
    check_eq("rst_vld", bus.out_valid, 0);
    check_eq("rst_cnt", bus.decode_cnt, 0);
    check_eq("rst_imm", bus.imm, 0);
    check_eq("rst_pc",  bus.out_pc, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed decode vectors, output always ready
    bus.out_ready = 1'b1;
    send_dir(32'h00500093, 32'h1000, 3'd1, 32'h00000005, 5'd1, 1'b0);
    check_eq("lat_vld", bus.out_valid, 1);
    check_eq("lat_pc",  bus.out_pc, 32'h1000);
    send_dir(32'hFE20AE23, 32'h1004, 3'd2, 32'hFFFFFFFC, 5'd0, 1'b0);
    send_dir(32'hFE000CE3, 32'h1008, 3'd3, 32'hFFFFFFF8, 5'd0, 1'b0);
    send_dir(32'h123452B7, 32'h100C, 3'd4, 32'h12345000, 5'd5, 1'b0);
    send_dir(32'h001000EF, 32'h1010, 3'd5, 32'h00000800, 5'd1, 1'b0);
    send_dir(32'h00000000, 32'h1014, 3'd7, 32'h00000000, 5'd0, 1'b1);
    send_dir(32'hFFFFFFFF, 32'h1018, 3'd7, 32'h00000000, 5'd0, 1'b1);
    drain();

    // Backpressure: skid fills on the 2nd accept, then everything exits in order
    do_reset();
    bus.out_ready = 1'b0;
    send_m(32'h00100113, 32'h2000);
    check_eq("rdy_after1", bus.in_ready, 1);
    send_m(32'h00208193, 32'h2004);
    check_eq("rdy_after2", bus.in_ready, 0);
    fork
      begin
        send_m(32'h00310233, 32'h2008);
        send_m(32'h004182B3, 32'h200C);
      end
      begin
        repeat (3) @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("cnt4", bus.decode_cnt, 4);

    // Flush with skid full and a concurrent input request
    bus.out_ready = 1'b0;
    send_m(32'h00500313, 32'h3000);
    send_m(32'h00600393, 32'h3004);
    cur          = model(32'h00700413, 32'h3008);
    bus.in_insn  = 32'h00700413;
    bus.in_pc    = 32'h3008;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("fl_vld", bus.out_valid, 0);
    check_eq("fl_rdy", bus.in_ready, 1);
    check_eq("fl_cnt", bus.decode_cnt, 4);

    // Flush while in_ready is high: the concurrent accept is dropped
    send_m(32'h00800493, 32'h3010);
    cur          = model(32'h00900513, 32'h3014);
    bus.in_insn  = 32'h00900513;
    bus.in_pc    = 32'h3014;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("fl2_vld", bus.out_valid, 0);
    @(negedge clk);
    check_eq("fl2_vld_hold", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Flush in the same cycle as an output handshake still counts it
    send_m(32'h00A00593, 32'h3020);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_eq("fl3_cnt", bus.decode_cnt, 5);
    check_eq("fl3_vld", bus.out_valid, 0);
    send_m(32'h00B00613, 32'h3024);
    drain();
    check_eq("fl3_cnt_after", bus.decode_cnt, 6);

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send_m(32'h00C00693, 32'h4000);
    send_m(32'h00D00713, 32'h4004);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_vld", bus.out_valid, 0);
    check_eq("arst_cnt", bus.decode_cnt, 0);
    check_eq("arst_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random stream with random output backpressure
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          r = $urandom();
          send_m({r[31:7], ops[$urandom_range(0, 11)]}, 32'h8000 + 32'(k * 4));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check_eq("rnd_cnt", bus.decode_cnt, exp_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
